// File: rtl/cpuif_arbiter_pkg.sv
// Shared types and helpers for the cpuif round-robin arbiter.
package cpuif_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE      = 1'b0,
        ARB_WAIT_RESP = 1'b1
    } arb_state_e;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpuif_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, modulo N.
module cpuif_rr_pick
    import cpuif_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        // Rotate so that bit 0 is the master at ptr, then find the lowest set bit.
        req_dbl = {req, req};
        req_rot = N'(req_dbl >> ptr);
        valid   = 1'b0;
        off     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                valid = 1'b1;
                off   = IDX_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/cpuif_arbiter.sv
// Round-robin arbiter sharing one passthrough cpuif between N_MASTERS requesters,
// one transaction in flight, with an optional response timeout.
module cpuif_arbiter
    import cpuif_arbiter_pkg::*;
#(
    parameter int  N_MASTERS      = 2,
    parameter int  ADDR_WIDTH     = 32,
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = idx_width(N_MASTERS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTERS-1:0]           m_req,
    input  logic [N_MASTERS-1:0]           m_req_is_wr,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wr_data,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wr_biten,
    output logic [N_MASTERS-1:0]           m_req_stall_wr,
    output logic [N_MASTERS-1:0]           m_req_stall_rd,
    output logic [N_MASTERS-1:0]           m_rd_ack,
    output logic [N_MASTERS-1:0]           m_rd_err,
    output logic [N_MASTERS-1:0]           m_wr_ack,
    output logic [N_MASTERS-1:0]           m_wr_err,
    output logic [DATA_WIDTH-1:0]          m_rd_data,
    output logic                           s_cpuif_req,
    output logic                           s_cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0]          s_cpuif_addr,
    output logic [DATA_WIDTH-1:0]          s_cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]          s_cpuif_wr_biten,
    input  logic                           s_cpuif_req_stall_wr,
    input  logic                           s_cpuif_req_stall_rd,
    input  logic                           s_cpuif_rd_ack,
    input  logic                           s_cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]          s_cpuif_rd_data,
    input  logic                           s_cpuif_wr_ack,
    input  logic                           s_cpuif_wr_err,
    output logic                           busy,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           stray_ack
);

    localparam int               CNT_W    = idx_width(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             owner_is_wr_q, owner_is_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_hold_q, rst_hold_d;

    logic             hold, in_idle, in_wait, any_ack, timeout, done;
    logic             fwd, accept, win_valid, win_is_wr;
    logic [IDX_W-1:0] win_idx;
    logic             resp_rd_ack, resp_rd_err, resp_wr_ack, resp_wr_err;

    cpuif_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (m_req),
        .ptr   (rr_ptr_q),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        // Outputs stay inert during reset and on the first cycle after release.
        rst_hold_d  = rst;
        hold        = rst | rst_hold_q;
        in_idle     = !hold && (state_q == ARB_IDLE);
        in_wait     = !hold && (state_q == ARB_WAIT_RESP);
        any_ack     = s_cpuif_rd_ack | s_cpuif_wr_ack;
        win_is_wr   = m_req_is_wr[win_idx];
        fwd         = in_idle & win_valid;
        accept      = fwd & ~(win_is_wr ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd);
        timeout     = in_wait & ~any_ack & (TIMEOUT_CYCLES > 0) & (cnt_q == TO_LAST);
        done        = in_wait & (any_ack | timeout);

        // A real ack wins over the timeout and keeps its own type.
        resp_rd_ack = in_wait & (s_cpuif_rd_ack | (timeout & ~owner_is_wr_q));
        resp_rd_err = in_wait & ((s_cpuif_rd_ack & s_cpuif_rd_err) | (timeout & ~owner_is_wr_q));
        resp_wr_ack = in_wait & (s_cpuif_wr_ack | (timeout & owner_is_wr_q));
        resp_wr_err = in_wait & ((s_cpuif_wr_ack & s_cpuif_wr_err) | (timeout & owner_is_wr_q));
        m_rd_data   = (in_wait & s_cpuif_rd_ack) ? s_cpuif_rd_data : '0;

        s_cpuif_req       = fwd;
        s_cpuif_req_is_wr = fwd & win_is_wr;
        s_cpuif_addr      = fwd ? m_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        s_cpuif_wr_data   = fwd ? m_wr_data[win_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
        s_cpuif_wr_biten  = fwd ? m_wr_biten[win_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

        busy      = in_wait;
        stray_ack = in_idle & any_ack;
        if (in_wait) begin
            grant_idx = owner_q;
        end else if (fwd) begin
            grant_idx = win_idx;
        end else begin
            grant_idx = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        owner_is_wr_d = owner_is_wr_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    state_d       = ARB_WAIT_RESP;
                    owner_d       = win_idx;
                    owner_is_wr_d = win_is_wr;
                    cnt_d         = '0;
                end
            end
            ARB_WAIT_RESP: begin
                if (done) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_hold_q <= rst_hold_d;
        if (rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= '0;
            owner_is_wr_q <= 1'b0;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            owner_is_wr_q <= owner_is_wr_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
        logic is_owner, is_winner;
        assign is_owner           = (owner_q == IDX_W'(gi));
        assign is_winner          = fwd && (win_idx == IDX_W'(gi));
        assign m_rd_ack[gi]       = is_owner & resp_rd_ack;
        assign m_rd_err[gi]       = is_owner & resp_rd_err;
        assign m_wr_ack[gi]       = is_owner & resp_wr_ack;
        assign m_wr_err[gi]       = is_owner & resp_wr_err;
        assign m_req_stall_wr[gi] = is_winner ? s_cpuif_req_stall_wr : 1'b1;
        assign m_req_stall_rd[gi] = is_winner ? s_cpuif_req_stall_rd : 1'b1;
    end

endmodule

// File: tb/tb_cpuif_arbiter.sv
// Self-checking bench for cpuif_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_cpuif_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req, m_req_is_wr;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wr_data, m_wr_biten;
    logic [N-1:0]    m_req_stall_wr, m_req_stall_rd;
    logic [N-1:0]    m_rd_ack, m_rd_err, m_wr_ack, m_wr_err;
    logic [DW-1:0]   m_rd_data;
    logic            s_req, s_is_wr;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wr_data, s_wr_biten, s_rd_data;
    logic            s_stall_wr, s_stall_rd, s_rd_ack, s_rd_err, s_wr_ack, s_wr_err;
    logic            busy, stray_ack;
    logic [IW-1:0]   grant_idx;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: is a transaction outstanding, whose, and for how long.
    bit mdl_busy, mdl_owner_wr, mdl_rst_prev, mdl_accept;
    int mdl_owner, mdl_ptr, mdl_wait, mdl_acc_idx, n_txn;

    bit            obs_acc;
    int            obs_acc_idx;
    logic [N-1:0]  obs_rd_ack, obs_rd_err, obs_wr_ack, obs_swr;
    logic [DW-1:0] obs_rd_data;
    logic          obs_busy, obs_stray;

    cpuif_arbiter #(
        .N_MASTERS      (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .m_req                (m_req),
        .m_req_is_wr          (m_req_is_wr),
        .m_addr               (m_addr),
        .m_wr_data            (m_wr_data),
        .m_wr_biten           (m_wr_biten),
        .m_req_stall_wr       (m_req_stall_wr),
        .m_req_stall_rd       (m_req_stall_rd),
        .m_rd_ack             (m_rd_ack),
        .m_rd_err             (m_rd_err),
        .m_wr_ack             (m_wr_ack),
        .m_wr_err             (m_wr_err),
        .m_rd_data            (m_rd_data),
        .s_cpuif_req          (s_req),
        .s_cpuif_req_is_wr    (s_is_wr),
        .s_cpuif_addr         (s_addr),
        .s_cpuif_wr_data      (s_wr_data),
        .s_cpuif_wr_biten     (s_wr_biten),
        .s_cpuif_req_stall_wr (s_stall_wr),
        .s_cpuif_req_stall_rd (s_stall_rd),
        .s_cpuif_rd_ack       (s_rd_ack),
        .s_cpuif_rd_err       (s_rd_err),
        .s_cpuif_rd_data      (s_rd_data),
        .s_cpuif_wr_ack       (s_wr_ack),
        .s_cpuif_wr_err       (s_wr_err),
        .busy                 (busy),
        .grant_idx            (grant_idx),
        .stray_ack            (stray_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are set just after a falling edge; sample #1 later, then step the model.
    task automatic cycle();
        logic [N-1:0]  e_swr, e_srd, e_rack, e_rerr, e_wack, e_werr;
        logic [DW-1:0] e_rdata;
        bit hold, e_sreq, e_busy, e_stray, done, timed_out, chk_grant;
        int w, e_grant;
        #1;
        hold = rst || mdl_rst_prev;
        e_swr = '1; e_srd = '1;
        e_rack = '0; e_rerr = '0; e_wack = '0; e_werr = '0; e_rdata = '0;
        e_sreq = 0; e_busy = 0; e_stray = 0; done = 0; timed_out = 0; chk_grant = 1;
        w = -1; e_grant = 0;
        mdl_accept = 0;
        if (!hold && !mdl_busy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mdl_ptr + k) % N;
                if (w < 0 && m_req[j]) w = j;
            end
            e_stray = s_rd_ack || s_wr_ack;
            if (w >= 0) begin
                e_sreq = 1; e_grant = w;
                e_swr[w] = s_stall_wr; e_srd[w] = s_stall_rd;
                mdl_accept = m_req_is_wr[w] ? !s_stall_wr : !s_stall_rd;
            end else begin
                chk_grant = 0;
            end
        end else if (!hold) begin
            e_busy = 1; e_grant = mdl_owner;
            mdl_wait++;
            if (s_rd_ack || s_wr_ack) begin
                e_rack[mdl_owner] = s_rd_ack; e_rerr[mdl_owner] = s_rd_ack && s_rd_err;
                e_wack[mdl_owner] = s_wr_ack; e_werr[mdl_owner] = s_wr_ack && s_wr_err;
                if (s_rd_ack) e_rdata = s_rd_data;
                done = 1;
            end else if (mdl_wait == TO) begin
                if (mdl_owner_wr) begin
                    e_wack[mdl_owner] = 1; e_werr[mdl_owner] = 1;
                end else begin
                    e_rack[mdl_owner] = 1; e_rerr[mdl_owner] = 1;
                end
                done = 1; timed_out = 1;
            end
        end

        check("stall_wr", m_req_stall_wr, e_swr);
        check("stall_rd", m_req_stall_rd, e_srd);
        check("rd_ack", m_rd_ack, e_rack);
        check("rd_err", m_rd_err, e_rerr);
        check("wr_ack", m_wr_ack, e_wack);
        check("wr_err", m_wr_err, e_werr);
        check("rd_data", m_rd_data, e_rdata);
        check("s_req", s_req, e_sreq);
        check("busy", busy, e_busy);
        check("stray_ack", stray_ack, e_stray);
        if (chk_grant) check("grant_idx", grant_idx, e_grant);
        if (hold) begin
            check("rst_s_is_wr", s_is_wr, 0);
            check("rst_s_addr", s_addr, 0);
            check("rst_s_wr_data", s_wr_data, 0);
            check("rst_s_wr_biten", s_wr_biten, 0);
        end else if (e_sreq) begin
            check("s_is_wr", s_is_wr, m_req_is_wr[w]);
            check("s_addr", s_addr, m_addr[w*AW +: AW]);
            check("s_wr_data", s_wr_data, m_wr_data[w*DW +: DW]);
            check("s_wr_biten", s_wr_biten, m_wr_biten[w*DW +: DW]);
        end

        obs_acc     = s_req && !(s_is_wr ? s_stall_wr : s_stall_rd);
        obs_acc_idx = int'(grant_idx);
        obs_rd_ack  = m_rd_ack;  obs_rd_err = m_rd_err;
        obs_wr_ack  = m_wr_ack;  obs_swr    = m_req_stall_wr;
        obs_rd_data = m_rd_data; obs_busy   = busy; obs_stray = stray_ack;

        if (rst) begin
            mdl_busy = 0; mdl_ptr = 0; mdl_wait = 0;
        end else if (mdl_accept) begin
            mdl_busy = 1; mdl_owner = w; mdl_owner_wr = m_req_is_wr[w];
            mdl_wait = 0; mdl_acc_idx = w;
        end else if (done) begin
            mdl_busy = 0; mdl_ptr = (mdl_owner + 1) % N; n_txn++;
            $display("txn %0d: master %0d %s %s", n_txn, mdl_owner,
                     mdl_owner_wr ? "wr" : "rd", timed_out ? "timeout" : "acked");
        end
        mdl_rst_prev = rst;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_req = '0; m_req_is_wr = '0; m_addr = '0; m_wr_data = '0; m_wr_biten = '0;
        s_stall_wr = 0; s_stall_rd = 0; s_rd_ack = 0; s_rd_err = 0;
        s_wr_ack = 0; s_wr_err = 0; s_rd_data = '0;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_req[i] = 1; m_req_is_wr[i] = wr;
        m_addr[i*AW +: AW] = a; m_wr_data[i*DW +: DW] = d; m_wr_biten[i*DW +: DW] = '1;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        cycle();
    endtask

    initial begin
        int order [6];
        int n, k;
        bit pend;
        mdl_busy = 0; mdl_owner = 0; mdl_owner_wr = 0; mdl_rst_prev = 1;
        mdl_ptr = 0; mdl_wait = 0; mdl_acc_idx = 0; n_txn = 0;
        clear_inputs();
        rst = 1;
        @(negedge clk);

        // Single read, plus reset-value checks
        reset_dut();
        check("t1_reset_busy", obs_busy, 0);
        check("t1_reset_stall", obs_swr, 3'b111);
        set_req(0, 0, 16'h0010, 0);
        cycle();
        check("t1_accept", obs_acc, 1);
        m_req = '0;
        s_rd_ack = 1; s_rd_data = 32'hDEADBEEF;
        cycle();
        check("t1_rd_ack", obs_rd_ack, 3'b001);
        check("t1_rd_data", obs_rd_data, 32'hDEADBEEF);
        s_rd_ack = 0; s_rd_data = '0;
        cycle();
        check("t1_busy_after", obs_busy, 0);

        // Simultaneous writes
        reset_dut();
        set_req(0, 1, 16'h0100, 32'h11111111);
        set_req(1, 1, 16'h0200, 32'h22222222);
        cycle();
        check("t2_first_acc", obs_acc, 1);
        check("t2_first_idx", obs_acc_idx, 0);
        check("t2_m1_stalled", obs_swr[1], 1);
        m_req[0] = 0;
        s_wr_ack = 1;
        cycle();
        check("t2_m0_ack", obs_wr_ack, 3'b001);
        check("t2_no_acc_in_ack", obs_acc, 0);
        s_wr_ack = 0;
        cycle();
        check("t2_second_acc", obs_acc, 1);
        check("t2_second_idx", obs_acc_idx, 1);
        m_req[1] = 0;
        s_wr_ack = 1;
        cycle();
        check("t2_m1_ack", obs_wr_ack, 3'b010);
        clear_inputs();
        cycle();

        // Fairness with two continuous requesters
        reset_dut();
        set_req(0, 0, 16'h0030, 0);
        set_req(1, 0, 16'h0040, 0);
        foreach (order[i]) order[i] = -1;
        n = 0; pend = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            s_rd_ack = pend; s_rd_data = $urandom;
            cycle();
            pend = obs_acc;
            if (obs_acc) begin
                order[n] = obs_acc_idx;
                n++;
            end
        end
        check("t3_count", n, 6);
        for (int i = 0; i < 6; i++) check("t3_order", order[i], i % 2);
        clear_inputs();
        cycle();
        cycle();

        // Regblock write stall
        reset_dut();
        set_req(0, 1, 16'h0050, 32'hA5A5A5A5);
        set_req(1, 1, 16'h0060, 32'h5A5A5A5A);
        s_stall_wr = 1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("t4_stalled", obs_swr, 3'b111);
            check("t4_no_acc", obs_acc, 0);
        end
        s_stall_wr = 0;
        cycle();
        check("t4_acc", obs_acc, 1);
        check("t4_acc_idx", obs_acc_idx, 0);
        check("t4_stall_after", obs_swr, 3'b110);
        clear_inputs();
        s_wr_ack = 1;
        cycle();
        s_wr_ack = 0;
        cycle();

        // Timeout then stray ack
        reset_dut();
        set_req(0, 0, 16'h0070, 0);
        cycle();
        check("t5_accept", obs_acc, 1);
        m_req = '0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            k++;
            if (obs_rd_err[0]) break;
        end
        check("t5_latency", k, TO);
        check("t5_rd_ack", obs_rd_ack, 3'b001);
        check("t5_rd_data", obs_rd_data, 0);
        cycle();
        s_rd_ack = 1; s_rd_data = 32'h12345678;
        cycle();
        check("t5_stray", obs_stray, 1);
        check("t5_no_master_ack", obs_rd_ack, 0);
        s_rd_ack = 0;
        cycle();

        // Reset mid-transaction
        reset_dut();
        set_req(0, 0, 16'h0080, 0);
        cycle();
        m_req = '0;
        cycle();
        check("t6_busy_before", obs_busy, 1);
        rst = 1;
        cycle();
        check("t6_busy_rst", obs_busy, 0);
        s_rd_ack = 1;
        cycle();
        check("t6_no_ack_rst", obs_rd_ack, 0);
        s_rd_ack = 0; rst = 0;
        cycle();
        s_rd_ack = 1;
        cycle();
        check("t6_stray", obs_stray, 1);
        s_rd_ack = 0;
        set_req(0, 0, 16'h0090, 0);
        set_req(1, 0, 16'h00A0, 0);
        cycle();
        check("t6_acc_idx", obs_acc_idx, 0);
        clear_inputs();
        s_rd_ack = 1;
        cycle();
        s_rd_ack = 0;
        cycle();

        // Randomized traffic
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_req[i] && $urandom_range(2) == 0)
                    set_req(i, 1'($urandom_range(1)), AW'($urandom), $urandom);
            end
            s_stall_wr = ($urandom_range(3) == 0);
            s_stall_rd = ($urandom_range(3) == 0);
            s_rd_ack = 0; s_wr_ack = 0; s_rd_err = 0; s_wr_err = 0;
            s_rd_data = $urandom;
            if ($urandom_range(3) == 0) begin
                bit t;
                t = mdl_owner_wr;
                if ($urandom_range(7) == 0) t = !t;
                if (t) begin
                    s_wr_ack = 1; s_wr_err = ($urandom_range(7) == 0);
                end else begin
                    s_rd_ack = 1; s_rd_err = ($urandom_range(7) == 0);
                end
            end
            rst = ($urandom_range(299) == 0);
            cycle();
            if (mdl_accept) m_req[mdl_acc_idx] = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
